pack_frame: RTL

Frame assembler that sits directly downstream of the sample loader in the pack path. On `fire_pack` it emits a sync/header sequence, then triggers the loader with `fire_load`. It forwards every loaded byte into a single byte stream, appends a two's-complement checksum, and reports completion and length errors. Its output stream feeds the transmit/packet-RAM stage at one byte per valid cycle, with no backpressure.

---
 rtl/pack_frame_if.sv | 25 ++
 rtl/pack_frame.sv | 117 +++++++++++
 2 files changed

// File: rtl/pack_frame_if.sv
// Signals between the frame assembler, its trigger, the sample loader and the transmit stage.
// The master modport is the assembler's view; slave is the surrounding logic.
interface pack_frame_if;
    logic        fire_pack;
    logic        done_pack;
    logic        pack_err;
    logic        fire_load;
    logic        done_load;
    logic [7:0]  load_data;
    logic        load_vld;
    logic [11:0] len_load;
    logic [7:0]  pack_data;
    logic        pack_vld;
    logic [7:0]  frame_cnt;

    modport master (
        input  fire_pack, done_load, load_data, load_vld, len_load,
        output done_pack, pack_err, fire_load, pack_data, pack_vld, frame_cnt
    );

    modport slave (
        output fire_pack, done_load, load_data, load_vld, len_load,
        input  done_pack, pack_err, fire_load, pack_data, pack_vld, frame_cnt
    );
endinterface

// File: rtl/pack_frame.sv
// Frame assembler: sync/header bytes, loader payload, two's-complement checksum,
// length/timeout error flag, one byte per valid cycle with no backpressure.
module pack_frame #(
    parameter logic [7:0]  SYNC0   = 8'hEB,
    parameter logic [7:0]  SYNC1   = 8'h90,
    parameter logic [15:0] TMO_MAX = 16'hFFFF
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    pack_frame_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_SYNC0, S_SYNC1, S_FCNT, S_LENH,
        S_LENL, S_FIRE, S_LOAD, S_SUM, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] len_q;
    logic [7:0]  sum_q;
    logic [15:0] byte_cnt;
    logic [15:0] tmo_cnt;
    logic [15:0] len_x9;
    logic [7:0]  frame_cnt_q;
    logic        pack_err_q;
    logic [7:0]  pack_data_q;
    logic        pack_vld_q;
    logic        emit;
    logic [7:0]  emit_byte;
    logic        start;
    logic        timeout;
    logic        add_sum;

    assign start   = (state == S_IDLE) && bus.fire_pack;
    // done_load wins over a timeout that lands on the same cycle.
    assign timeout = (state == S_LOAD) && !bus.done_load && ((tmo_cnt + 16'd1) == TMO_MAX);
    // 9 * len_q as (8 * len_q) + len_q; fits in 16 bits for any 12-bit length.
    assign len_x9  = {1'b0, len_q, 3'b000} + {4'h0, len_q};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.fire_pack) state_nxt = S_SYNC0;
            S_SYNC0: state_nxt = S_SYNC1;
            S_SYNC1: state_nxt = S_FCNT;
            S_FCNT:  state_nxt = S_LENH;
            S_LENH:  state_nxt = S_LENL;
            S_LENL:  state_nxt = (len_q != 12'd0) ? S_FIRE : S_SUM;
            S_FIRE:  state_nxt = S_LOAD;
            S_LOAD:  if (bus.done_load || timeout) state_nxt = S_SUM;
            S_SUM:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        emit      = 1'b0;
        emit_byte = 8'h00;
        case (state)
            S_SYNC0: begin emit = 1'b1; emit_byte = SYNC0;                end
            S_SYNC1: begin emit = 1'b1; emit_byte = SYNC1;                end
            S_FCNT:  begin emit = 1'b1; emit_byte = frame_cnt_q;          end
            S_LENH:  begin emit = 1'b1; emit_byte = {4'h0, len_q[11:8]};  end
            S_LENL:  begin emit = 1'b1; emit_byte = len_q[7:0];           end
            S_LOAD:  begin emit = bus.load_vld; emit_byte = bus.load_data; end
            S_SUM:   begin emit = 1'b1; emit_byte = 8'h00 - sum_q;        end
            default: ;
        endcase
    end

    // Sync bytes and the checksum itself stay out of the running sum.
    assign add_sum = emit && (state inside {S_FCNT, S_LENH, S_LENL, S_LOAD});

    // NOTE: the asynchronous reset clears every register here; there are no storage arrays to exempt.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            len_q       <= 12'd0;
            sum_q       <= 8'h00;
            byte_cnt    <= 16'd0;
            tmo_cnt     <= 16'd0;
            frame_cnt_q <= 8'h00;
            pack_err_q  <= 1'b0;
            pack_data_q <= 8'h00;
            pack_vld_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_nxt;
            pack_vld_q  <= emit;
            pack_data_q <= emit ? emit_byte : 8'h00;
            if (start) begin
                len_q      <= bus.len_load;
                sum_q      <= 8'h00;
                byte_cnt   <= 16'd0;
                tmo_cnt    <= 16'd0;
                pack_err_q <= 1'b0;
            end else begin
                if (add_sum) sum_q <= sum_q + emit_byte;
                if (state == S_LOAD) begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (bus.load_vld) byte_cnt <= byte_cnt + 16'd1;
                end
                if (timeout) pack_err_q <= 1'b1;
                if ((state == S_SUM) && (byte_cnt != len_x9)) pack_err_q <= 1'b1;
                if (state == S_DONE) frame_cnt_q <= frame_cnt_q + 8'h01;
            end
        end
    end

    assign bus.pack_data = pack_data_q;
    assign bus.pack_vld  = pack_vld_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.pack_err  = pack_err_q;
    assign bus.fire_load = (state == S_FIRE);
    assign bus.done_pack = (state == S_DONE);
endmodule
